// File: rtl/stack_seq_ctrl_pkg.sv
// Shared types and constants for the return-stack sequencer.
// Holds the FSM state enum, fault codes and default widths.
package stack_seq_ctrl_pkg;

    localparam int DATA_W_DEF  = 19;
    localparam int SP_W_DEF    = 4;
    localparam int FLAGS_W_DEF = 4;

    localparam logic [DATA_W_DEF-1:0] IRQ_VECTOR_DEF = 19'h00010;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_OVF  = 2'd1;
    localparam logic [1:0] FAULT_UNF  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        CALL_PUSH,
        RET_POP,
        IRQ_PUSH_PC,
        IRQ_PUSH_FLG,
        RETI_POP_FLG,
        RETI_POP_PC,
        FINISH
    } state_t;

endpackage

// File: rtl/stack_seq_ctrl.sv
// Return-stack sequencer: turns CALL/RET/IRQ/RETI into push/pop strobes.
// Build option STACK_FAULT_STICKY_EN makes fault/fault_code sticky until fault_clr.
module stack_seq_ctrl
    import stack_seq_ctrl_pkg::*;
#(
    parameter int                 DATA_W     = DATA_W_DEF,
    parameter int                 SP_W       = SP_W_DEF,
    parameter int                 FLAGS_W    = FLAGS_W_DEF,
    parameter logic [DATA_W-1:0]  IRQ_VECTOR = IRQ_VECTOR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call_req,
    input  logic [DATA_W-1:0]  call_target,
    input  logic               ret_req,
    input  logic               irq_req,
    input  logic               reti_req,
    input  logic [DATA_W-1:0]  pc,
    input  logic [FLAGS_W-1:0] flags_in,
    input  logic               fault_clr,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [DATA_W-1:0]  stk_push_data,
    input  logic [DATA_W-1:0]  stk_pop_data,
    input  logic [SP_W-1:0]    stk_sp,
    input  logic               stk_empty,
    input  logic               stk_full,
    output logic               busy,
    output logic               done,
    output logic               pc_load,
    output logic [DATA_W-1:0]  pc_next,
    output logic               flags_restore,
    output logic [FLAGS_W-1:0] flags_out,
    output logic               fault,
    output logic [1:0]         fault_code
);

    // An IRQ needs two free slots; a RETI needs two occupied ones.
    localparam logic [SP_W-1:0] IRQ_MIN_SP  = SP_W'(2);
    localparam logic [SP_W-1:0] RETI_MAX_SP = SP_W'((1 << SP_W) - 3);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  target_q, target_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic [DATA_W-1:0]  pc_next_q, pc_next_d;
    logic [FLAGS_W-1:0] flags_out_q, flags_out_d;
    logic               restore_q, restore_d;
    logic [1:0]         code_q, code_d;
    logic               faultDetect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            target_q    <= '0;
            flags_q     <= '0;
            pc_next_q   <= '0;
            flags_out_q <= '0;
            restore_q   <= 1'b0;
            code_q      <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            flags_q     <= flags_d;
            pc_next_q   <= pc_next_d;
            flags_out_q <= flags_out_d;
            restore_q   <= restore_d;
            code_q      <= code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        flags_d       = flags_q;
        pc_next_d     = pc_next_q;
        flags_out_d   = flags_out_q;
        restore_d     = restore_q;
        code_d        = code_q;
        faultDetect   = 1'b0;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_push_data = '0;
        done          = 1'b0;
        pc_load       = 1'b0;
        flags_restore = 1'b0;

        case (state_q)
            IDLE: begin
                if (irq_req || reti_req || call_req || ret_req) begin
                    pc_d      = pc;
                    target_d  = call_target;
                    flags_d   = flags_in;
                    restore_d = 1'b0;
                    code_d    = FAULT_NONE;
                end
                // A failed capacity check skips straight to FINISH without touching the stack.
                if (irq_req) begin
                    if (stk_sp < IRQ_MIN_SP) begin
                        code_d  = FAULT_OVF;
                        state_d = FINISH;
                    end else begin
                        state_d = IRQ_PUSH_PC;
                    end
                end else if (reti_req) begin
                    if (stk_sp > RETI_MAX_SP) begin
                        code_d  = FAULT_UNF;
                        state_d = FINISH;
                    end else begin
                        state_d = RETI_POP_FLG;
                    end
                end else if (call_req) begin
                    if (stk_full) begin
                        code_d  = FAULT_OVF;
                        state_d = FINISH;
                    end else begin
                        state_d = CALL_PUSH;
                    end
                end else if (ret_req) begin
                    if (stk_empty) begin
                        code_d  = FAULT_UNF;
                        state_d = FINISH;
                    end else begin
                        state_d = RET_POP;
                    end
                end
                faultDetect = (code_d != FAULT_NONE) && (state_d == FINISH);
            end
            CALL_PUSH: begin
                stk_push      = 1'b1;
                stk_push_data = pc_q + DATA_W'(1);
                pc_next_d     = target_q;
                state_d       = FINISH;
            end
            RET_POP: begin
                stk_pop   = 1'b1;
                pc_next_d = stk_pop_data;
                state_d   = FINISH;
            end
            IRQ_PUSH_PC: begin
                stk_push      = 1'b1;
                stk_push_data = pc_q;
                state_d       = IRQ_PUSH_FLG;
            end
            IRQ_PUSH_FLG: begin
                stk_push      = 1'b1;
                stk_push_data = DATA_W'(flags_q);
                pc_next_d     = IRQ_VECTOR;
                state_d       = FINISH;
            end
            RETI_POP_FLG: begin
                stk_pop     = 1'b1;
                flags_out_d = stk_pop_data[FLAGS_W-1:0];
                state_d     = RETI_POP_PC;
            end
            RETI_POP_PC: begin
                stk_pop   = 1'b1;
                pc_next_d = stk_pop_data;
                restore_d = 1'b1;
                state_d   = FINISH;
            end
            FINISH: begin
                done          = 1'b1;
                pc_load       = (code_q == FAULT_NONE);
                flags_restore = restore_q;
                restore_d     = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STACK_FAULT_STICKY_EN
    logic       stickyFault_q;
    logic [1:0] stickyCode_q;

    // The first fault wins; fault_clr beats a fault detected in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stickyFault_q <= 1'b0;
            stickyCode_q  <= FAULT_NONE;
        end else if (fault_clr) begin
            stickyFault_q <= 1'b0;
            stickyCode_q  <= FAULT_NONE;
        end else if (faultDetect && !stickyFault_q) begin
            stickyFault_q <= 1'b1;
            stickyCode_q  <= code_d;
        end
    end

    assign fault      = stickyFault_q;
    assign fault_code = stickyCode_q;
`else
    logic unused_fault_clr;
    logic unused_fault_detect;

    assign unused_fault_clr    = fault_clr;
    assign unused_fault_detect = faultDetect;
    assign fault      = (state_q == FINISH) && (code_q != FAULT_NONE);
    assign fault_code = fault ? code_q : FAULT_NONE;
`endif

    assign busy      = (state_q != IDLE);
    assign pc_next   = pc_next_q;
    assign flags_out = flags_out_q;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed testbench for stack_seq_ctrl with a behavioural 16-entry stack model.
// Honours STACK_FAULT_STICKY_EN when defined for the build.
module tb_stack_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        call_req, ret_req, irq_req, reti_req, fault_clr;
    logic [18:0] call_target, pc;
    logic [3:0]  flags_in;
    logic        stk_push, stk_pop;
    logic [18:0] stk_push_data, stk_pop_data;
    logic [3:0]  stk_sp;
    logic        stk_empty, stk_full;
    logic        busy, done, pc_load, flags_restore, fault;
    logic [18:0] pc_next;
    logic [3:0]  flags_out;
    logic [1:0]  fault_code;

    int assertCount = 0;
    int failCount   = 0;

    logic [18:0] mem [16];

    always #5 clk = ~clk;

    stack_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .call_req(call_req), .call_target(call_target),
        .ret_req(ret_req), .irq_req(irq_req), .reti_req(reti_req),
        .pc(pc), .flags_in(flags_in), .fault_clr(fault_clr),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_push_data(stk_push_data),
        .stk_pop_data(stk_pop_data), .stk_sp(stk_sp),
        .stk_empty(stk_empty), .stk_full(stk_full),
        .busy(busy), .done(done), .pc_load(pc_load), .pc_next(pc_next),
        .flags_restore(flags_restore), .flags_out(flags_out),
        .fault(fault), .fault_code(fault_code)
    );

    // Downward-growing stack: sp==15 empty, sp==0 full, top at sp+1.
    always @(posedge clk) begin
        if (reset) begin
            stk_sp <= 4'd15;
        end else if (stk_push) begin
            mem[stk_sp] <= stk_push_data;
            stk_sp      <= stk_sp - 4'd1;
        end else if (stk_pop) begin
            stk_sp <= stk_sp + 4'd1;
        end
    end

    assign stk_pop_data = mem[4'(stk_sp + 4'd1)];
    assign stk_empty    = (stk_sp == 4'd15);
    assign stk_full     = (stk_sp == 4'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Holds the chosen request(s) for one cycle, then drops them.
    task automatic applyStimulus(input logic c, input logic r, input logic i, input logic ri,
                                 input logic [18:0] p, input logic [18:0] t, input logic [3:0] f);
        call_req = c; ret_req = r; irq_req = i; reti_req = ri;
        pc = p; call_target = t; flags_in = f;
        tick();
        call_req = 1'b0; ret_req = 1'b0; irq_req = 1'b0; reti_req = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic doCall(input logic [18:0] p, input logic [18:0] t);
        applyStimulus(1, 0, 0, 0, p, t, 4'h0);
        tick();
        tick();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = '0;
        reset = 1'b1; call_req = 0; ret_req = 0; irq_req = 0; reti_req = 0; fault_clr = 0;
        pc = '0; call_target = '0; flags_in = '0;
        tick();
        resetDut();

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pc_next", pc_next, 0);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_fault_code", fault_code, 0);
        checkOutput("rst_push", stk_push, 0);

        // CALL
        applyStimulus(1, 0, 0, 0, 19'h00100, 19'h00200, 4'h0);
        checkOutput("call_push", stk_push, 1);
        checkOutput("call_push_data", stk_push_data, 19'h00101);
        checkOutput("call_busy", busy, 1);
        tick();
        checkOutput("call_done", done, 1);
        checkOutput("call_pc_load", pc_load, 1);
        checkOutput("call_pc_next", pc_next, 19'h00200);
        checkOutput("call_sp", stk_sp, 14);
        tick();
        checkOutput("call_idle", busy, 0);

        // RET
        applyStimulus(0, 1, 0, 0, 19'h00200, 19'h0, 4'h0);
        checkOutput("ret_pop", stk_pop, 1);
        checkOutput("ret_no_push", stk_push, 0);
        tick();
        checkOutput("ret_done", done, 1);
        checkOutput("ret_pc_load", pc_load, 1);
        checkOutput("ret_pc_next", pc_next, 19'h00101);
        checkOutput("ret_sp", stk_sp, 15);
        tick();

        // IRQ then RETI
        applyStimulus(0, 0, 1, 0, 19'h00050, 19'h0, 4'b1010);
        checkOutput("irq_push_pc", stk_push, 1);
        checkOutput("irq_push_pc_data", stk_push_data, 19'h00050);
        tick();
        checkOutput("irq_push_flg_data", stk_push_data, 19'h0000A);
        checkOutput("irq_flg_not_done", done, 0);
        tick();
        checkOutput("irq_done", done, 1);
        checkOutput("irq_pc_next", pc_next, 19'h00010);
        checkOutput("irq_pc_load", pc_load, 1);
        checkOutput("irq_sp", stk_sp, 13);
        tick();
        applyStimulus(0, 0, 0, 1, 19'h00012, 19'h0, 4'h0);
        checkOutput("reti_pop1", stk_pop, 1);
        tick();
        checkOutput("reti_pop2", stk_pop, 1);
        tick();
        checkOutput("reti_done", done, 1);
        checkOutput("reti_flags_restore", flags_restore, 1);
        checkOutput("reti_flags_out", flags_out, 4'b1010);
        checkOutput("reti_pc_next", pc_next, 19'h00050);
        checkOutput("reti_sp", stk_sp, 15);
        tick();
        checkOutput("reti_restore_drop", flags_restore, 0);

        // IRQ and CALL together, then a CALL while busy
        applyStimulus(1, 0, 1, 0, 19'h00060, 19'h00300, 4'h5);
        checkOutput("prio_push_data", stk_push_data, 19'h00060);
        call_req = 1'b1;
        tick();
        call_req = 1'b0;
        checkOutput("prio_flg_data", stk_push_data, 19'h00005);
        tick();
        checkOutput("prio_pc_next", pc_next, 19'h00010);
        tick();
        checkOutput("prio_idle", busy, 0);
        tick();
        checkOutput("prio_sp", stk_sp, 13);
        resetDut();

        // Underflow on empty stack
        applyStimulus(0, 1, 0, 0, 19'h00020, 19'h0, 4'h0);
        checkOutput("unf_done", done, 1);
        checkOutput("unf_fault", fault, 1);
        checkOutput("unf_code", fault_code, 2);
        checkOutput("unf_no_pc_load", pc_load, 0);
        checkOutput("unf_no_pop", stk_pop, 0);
        tick();
`ifdef STACK_FAULT_STICKY_EN
        checkOutput("unf_sticky", fault, 1);
        checkOutput("unf_sticky_code", fault_code, 2);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checkOutput("unf_cleared", fault, 0);
`else
        checkOutput("unf_pulse", fault, 0);
        checkOutput("unf_pulse_code", fault_code, 0);
`endif

        // Overflow: fill with 15 CALLs, the 16th faults
        for (int n = 0; n < 15; n++) doCall(19'(n), 19'(n + 32));
        checkOutput("fill_sp", stk_sp, 0);
        checkOutput("fill_pc_next", pc_next, 19'd46);
        applyStimulus(1, 0, 0, 0, 19'h00400, 19'h00500, 4'h0);
        checkOutput("ovf_done", done, 1);
        checkOutput("ovf_fault", fault, 1);
        checkOutput("ovf_code", fault_code, 1);
        checkOutput("ovf_no_push", stk_push, 0);
        checkOutput("ovf_no_pc_load", pc_load, 0);
        checkOutput("ovf_pc_next_kept", pc_next, 19'd46);
        tick();
        resetDut();

        // IRQ with only one free slot
        for (int n = 0; n < 14; n++) doCall(19'(n + 100), 19'(n + 200));
        checkOutput("irqovf_sp", stk_sp, 1);
        applyStimulus(0, 0, 1, 0, 19'h00077, 19'h0, 4'h3);
        checkOutput("irqovf_fault", fault, 1);
        checkOutput("irqovf_code", fault_code, 1);
        checkOutput("irqovf_no_push", stk_push, 0);
        tick();
        checkOutput("irqovf_sp_kept", stk_sp, 1);
        resetDut();

        // Reset during IRQ_PUSH_PC
        doCall(19'h00011, 19'h00222);
        applyStimulus(0, 0, 1, 0, 19'h00070, 19'h0, 4'h6);
        checkOutput("rstmid_push", stk_push, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_push_after", stk_push, 0);
        checkOutput("rstmid_pc_next", pc_next, 0);
        checkOutput("rstmid_done", done, 0);
        tick();
        checkOutput("rstmid_quiet", stk_push, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/stack_seq_ctrl.md
Name: stack_seq_ctrl

Overview:
- Sequencer that owns the 16-entry, 19-bit hardware return stack.
- Arbitrates CALL, RET, interrupt entry (IRQ) and RETI requests from the core and turns each into the correct sequence of stack push/pop strobes.
- Delivers the redirected PC, restored flags and overflow/underflow faults back to the core.
- Sits between the control unit and the stack; the only driver of the stack's push/pop.

Parameters:
- DATA_W, 19, PC and stack word width
- SP_W, 4, stack pointer width; capacity is 2**SP_W-1 = 15 entries; sp==15 empty, sp==0 full
- FLAGS_W, 4, core flag width; zero-extended to DATA_W when pushed
- IRQ_VECTOR, 19'h00010, PC loaded on interrupt entry

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- call_req  in  1  single-cycle CALL request
- call_target  in  DATA_W  CALL destination
- ret_req  in  1  single-cycle RET request
- irq_req  in  1  single-cycle interrupt-entry request
- reti_req  in  1  single-cycle RETI request
- pc  in  DATA_W  PC of the requesting instruction
- flags_in  in  FLAGS_W  core flags to save on IRQ
- fault_clr  in  1  clears sticky fault (used only with STACK_FAULT_STICKY_EN)
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_push_data  out  DATA_W  word to push
- stk_pop_data  in  DATA_W  top-of-stack word (combinational from the stack)
- stk_sp  in  SP_W  stack pointer
- stk_empty  in  1  stack empty
- stk_full  in  1  stack full
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- pc_load  out  1  one-cycle strobe: core loads pc_next
- pc_next  out  DATA_W  redirected PC
- flags_restore  out  1  one-cycle strobe: core loads flags_out
- flags_out  out  FLAGS_W  restored flags
- fault  out  1  stack fault
- fault_code  out  2  0 none, 1 overflow, 2 underflow

Behaviour:
- Reset: state IDLE; all outputs 0, including pc_next, flags_out and fault_code. Reset mid-sequence abandons the sequence with no further strobes.
- Requests are sampled only in IDLE; requests seen while busy=1 are dropped.
- Priority when requests coincide: irq > reti > call > ret.
- busy=1 in every state except IDLE.
- FSM states: IDLE, CALL_PUSH, RET_POP, IRQ_PUSH_PC, IRQ_PUSH_FLG, RETI_POP_FLG, RETI_POP_PC, FINISH.
- Accept cycle: latch pc, call_target and flags_in; check capacity; move to the first state of the sequence.
- Capacity checks:
  - CALL overflow if stk_full.
  - IRQ overflow if stk_sp < 2.
  - RET underflow if stk_empty.
  - RETI underflow if stk_sp > 13.
  - On a failed check, go directly to FINISH with the fault set; no push or pop occurs.
- CALL_PUSH: stk_push=1, stk_push_data = pc+1 (modulo 2**DATA_W). Then FINISH with pc_next = call_target.
- RET_POP: stk_pop=1; capture stk_pop_data into pc_next in the same cycle. Then FINISH.
- IRQ_PUSH_PC: push latched pc (resume address, not pc+1).
- IRQ_PUSH_FLG: push zero-extended flags. Then FINISH with pc_next = IRQ_VECTOR.
- RETI_POP_FLG: pop; flags_out = low FLAGS_W bits of the popped word.
- RETI_POP_PC: pop; capture pc_next. Then FINISH with flags_restore=1.
- FINISH: done=1. pc_load=1 unless faulted. Next state IDLE.
- Latency from request cycle T: CALL/RET done at T+2; IRQ/RETI done at T+3.
- stk_push and stk_pop are never asserted together.
- fault without macro: fault and fault_code are valid only in the FINISH cycle, and done is also asserted.

Optional Feature:
- Macro: STACK_FAULT_STICKY_EN.
- Defined: fault and fault_code hold until fault_clr=1 or reset. A new fault while sticky does not overwrite fault_code. fault_clr has priority over a simultaneous new fault.
- Undefined: fault is a one-cycle pulse; fault_clr is ignored.

Decomposition:
- Shared package: the FSM state enum, fault-code constants (FAULT_NONE, FAULT_OVF, FAULT_UNF), the DATA_W/SP_W defaults and IRQ_VECTOR.
- No sub-module is natural; a single FSM module.

Test Plan:
- Reset, then CALL with pc=0x00100 and target=0x00200: stk_push at T+1 with data 0x00101; done, pc_load and pc_next=0x00200 at T+2; stk_sp goes 15->14.
- RET after that CALL: stk_pop at T+1; pc_next=0x00101 with pc_load at T+2; stk_sp back to 15.
- IRQ with pc=0x00050 and flags=4'b1010: pushes 0x00050 then 0x0000A; pc_next=0x00010. A following RETI restores flags_out=4'b1010 and pc_next=0x00050 with flags_restore.
- irq_req and call_req in the same cycle: IRQ sequence only; the call is dropped. A call_req issued while busy is ignored.
- Overflow: 15 CALLs fill the stack; a 16th gives fault=1, fault_code=1, no push, no pc_load. An IRQ at stk_sp=1 also faults.
- Underflow: RET on an empty stack gives fault_code=2. With STACK_FAULT_STICKY_EN, fault stays high until a fault_clr pulse. Reset asserted during IRQ_PUSH_PC gives IDLE and zero outputs next cycle.
